// File: rtl/cpu_pkg.sv
// Shared state encoding, opcode constants and ALU op codes for the CPU control sequencer.
// The TRAP state is only present when CPU_SEQ_TRAP_EN is defined.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
`ifdef CPU_SEQ_TRAP_EN
        , ST_TRAP
`endif
    } state_e;

    localparam logic [6:0] OPC_LW   = 7'h03;
    localparam logic [6:0] OPC_ADDI = 7'h13;
    localparam logic [6:0] OPC_SW   = 7'h23;
    localparam logic [6:0] OPC_R    = 7'h33;
    localparam logic [6:0] OPC_BR   = 7'h63;
    localparam logic [6:0] OPC_JAL  = 7'h6F;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_ADDI,
        CLS_JAL,
        CLS_LW,
        CLS_SW,
        CLS_BR,
        CLS_BAD
    } ins_class_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       bit30;
    } ins_fields_t;

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational decode of the latched instruction fields into an instruction
// class, the ALU op code and the ALU operand select.
module cpu_seq_decode
    import cpu_pkg::*;
(
    input  ins_fields_t fields_i,
    output ins_class_e  cls_o,
    output logic [2:0]  alu_op_o,
    output logic        alu_src_o
);

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        cls_o     = CLS_BAD;
        alu_op_o  = ALU_ADD;
        alu_src_o = 1'b1;
        case (fields_i.opcode)
            OPC_LW:   cls_o = CLS_LW;
            OPC_SW:   cls_o = CLS_SW;
            OPC_ADDI: cls_o = CLS_ADDI;
            OPC_JAL:  cls_o = CLS_JAL;
            OPC_BR: begin
                cls_o     = CLS_BR;
                alu_src_o = 1'b0;
            end
            OPC_R: begin
                cls_o     = CLS_R;
                alu_src_o = 1'b0;
                case (fields_i.funct3)
                    3'b000:  alu_op_o = fields_i.bit30 ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_op_o = ALU_AND;
                    3'b110:  alu_op_o = ALU_OR;
                    default: alu_op_o = ALU_ADD;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FSM, retired-instruction counter and class register.
// Define CPU_SEQ_TRAP_EN to trap on unrecognised opcodes instead of retiring them as NOPs.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] ENTRY_POINT = 32'h28,
    parameter int          INS_LIMIT   = 43
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] ins,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Mem2Reg,
    output logic [2:0]  op,
    output logic        INT,
    output logic [31:0] entryPoint,
    output logic        pc_en,
    output logic        ir_en,
    output logic        busy,
    output logic        done,
    output logic [15:0] retired,
    output logic        trap
);

    localparam logic [15:0] LIMIT = 16'(INS_LIMIT);

    state_e      state_q, state_d;
    ins_fields_t fields_q, fields_d;
    logic [15:0] retired_q, retired_d;
    logic [15:0] retired_inc;
    ins_class_e  cls;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        retire;
    logic        unused_ins;

    assign unused_ins  = ^{ins[31], ins[29:15], ins[11:7]};
    assign entryPoint  = ENTRY_POINT;
    assign retired     = retired_q;
    assign retired_inc = retired_q + 16'd1;

    cpu_seq_decode u_decode (
        .fields_i  (fields_q),
        .cls_o     (cls),
        .alu_op_o  (alu_op),
        .alu_src_o (alu_src)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            fields_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            fields_q  <= fields_d;
            retired_q <= retired_d;
        end
    end

    // Outputs decode from the state register alone, so reset clears them at once.
    always_comb begin
        state_d   = state_q;
        fields_d  = fields_q;
        retired_d = retired_q;
        retire    = 1'b0;
        RegWrite  = 1'b0;
        ALUSrc    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Mem2Reg   = 1'b0;
        op        = '0;
        INT       = 1'b0;
        pc_en     = 1'b0;
        ir_en     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pc_en   = 1'b1;
                INT     = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_en   = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                fields_d = '{opcode: ins[6:0], funct3: ins[14:12], bit30: ins[30]};
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                ALUSrc = alu_src;
                op     = alu_op;
                case (cls)
                    CLS_LW, CLS_SW:           state_d = ST_MEM;
                    CLS_R, CLS_ADDI, CLS_JAL: state_d = ST_WB;
                    CLS_BR:                   retire  = 1'b1;
`ifdef CPU_SEQ_TRAP_EN
                    default:                  state_d = ST_TRAP;
`else
                    default:                  retire  = 1'b1;
`endif
                endcase
            end
            ST_MEM: begin
                ALUSrc   = alu_src;
                op       = alu_op;
                MemRead  = (cls == CLS_LW);
                MemWrite = (cls == CLS_SW);
                if (cls == CLS_LW) state_d = ST_WB;
                else               retire  = 1'b1;
            end
            ST_WB: begin
                ALUSrc   = alu_src;
                op       = alu_op;
                RegWrite = 1'b1;
                Mem2Reg  = (cls == CLS_LW);
                retire   = 1'b1;
            end
            ST_HALT: begin
                busy = 1'b0;
                done = 1'b1;
            end
`ifdef CPU_SEQ_TRAP_EN
            ST_TRAP: busy = 1'b0;
`endif
            default: state_d = ST_IDLE;
        endcase

        // The retiring cycle advances the PC and decides between the next fetch and halt.
        if (retire) begin
            pc_en     = 1'b1;
            retired_d = retired_inc;
            state_d   = (retired_inc == LIMIT) ? ST_HALT : ST_FETCH;
        end
    end

`ifdef CPU_SEQ_TRAP_EN
    assign trap = (state_q == ST_TRAP);
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed and random instruction streams
// compared against a per-instruction latency/strobe model, plus a small-limit instance.
module tb_cpu_sequencer;

    localparam logic [31:0] ENTRY = 32'h28;
    localparam int          LIMIT = 43;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start;
    logic [31:0] ins;
    logic        RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, INT, pc_en, ir_en, busy, done, trap;
    logic [2:0]  op;
    logic [31:0] entryPoint;
    logic [15:0] retired;

    cpu_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ins(ins),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .Mem2Reg(Mem2Reg), .op(op), .INT(INT), .entryPoint(entryPoint),
        .pc_en(pc_en), .ir_en(ir_en), .busy(busy), .done(done),
        .retired(retired), .trap(trap)
    );

    logic        l_rst_n, l_start;
    logic [31:0] l_ins;
    logic        l_rw, l_src, l_mr, l_mw, l_m2r, l_int, l_pc, l_ir, l_busy, l_done, l_trap;
    logic [2:0]  l_op;
    logic [31:0] l_ep;
    logic [15:0] l_ret;

    cpu_sequencer #(.INS_LIMIT(3)) u_lim (
        .clk(clk), .rst_n(l_rst_n), .start(l_start), .ins(l_ins),
        .RegWrite(l_rw), .ALUSrc(l_src), .MemRead(l_mr), .MemWrite(l_mw),
        .Mem2Reg(l_m2r), .op(l_op), .INT(l_int), .entryPoint(l_ep),
        .pc_en(l_pc), .ir_en(l_ir), .busy(l_busy), .done(l_done),
        .retired(l_ret), .trap(l_trap)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    // {RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op[2:0], INT, pc_en, ir_en, busy, done, trap}
    function automatic logic [13:0] obs();
        return {RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op, INT, pc_en, ir_en, busy, done, trap};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [6:0]  opcs [6];
        logic [2:0]  r_f3 [3];
        logic [31:0] w;
        opcs = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h63, 7'h6F};
        r_f3 = '{3'b000, 3'b111, 3'b110};
        w = $urandom;
        w[6:0] = opcs[$urandom_range(0, 5)];
        if (w[6:0] == 7'h33) w[14:12] = r_f3[$urandom_range(0, 2)];
        return w;
    endfunction

    // Runs one instruction starting with the FETCH cycle visible; checks every cycle.
    task automatic run_instr(input string name, input logic [31:0] w);
        int          lat;
        logic        wr, is_lw, is_sw, src, known;
        logic [2:0]  eop;
        logic [13:0] e, m;
        lat = 3; wr = 0; is_lw = 0; is_sw = 0; src = 1; eop = 3'b010; known = 1;
        case (w[6:0])
            7'h33: begin
                lat = 4; wr = 1; src = 0;
                case (w[14:12])
                    3'b000:  eop = w[30] ? 3'b110 : 3'b010;
                    3'b111:  eop = 3'b000;
                    3'b110:  eop = 3'b001;
                    default: known = 0;
                endcase
            end
            7'h13, 7'h6F: begin lat = 4; wr = 1; end
            7'h03:        begin lat = 5; wr = 1; is_lw = 1; end
            7'h23:        begin lat = 4; is_sw = 1; end
            7'h63:        src = 0;
            default:      known = 0;
        endcase
        ins = w;
        for (int k = 0; k < lat; k++) begin
            if (k == 2) ins = $urandom;
            e = '0;
            e[2]  = 1'b1;
            e[3]  = (k == 0);
            e[4]  = (k == lat - 1);
            e[13] = wr && (k == lat - 1);
            e[11] = is_lw && (k == 3);
            e[10] = is_sw && (k == 3);
            e[9]  = is_lw && (k == lat - 1);
            e[12] = src;
            e[8:6] = eop;
            m = '1;
            if (k < 2) begin m[12] = 1'b0; m[8:6] = 3'b000; end
            if (!known) m[8:6] = 3'b000;
            n_checks++;
            if ((obs() & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL %s cycle %0d (ins %h): ctl=%b want %b (mask %b)", name, k, w, obs(), e, m);
            end
            @(posedge clk); #1;
        end
        exp_ret++;
        n_checks++;
        if (retired !== 16'(exp_ret)) begin
            n_fail++;
            $display("FAIL %s retired: got %0d want %0d", name, retired, exp_ret);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ins = $urandom;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs() !== 14'd0 || retired !== 16'd0 || entryPoint !== ENTRY) begin
            n_fail++;
            $display("FAIL reset: ctl=%b retired=%0d ep=%h want ctl=0 retired=0 ep=%h", obs(), retired, entryPoint, ENTRY);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (obs() !== 14'd0 || retired !== 16'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: ctl=%b retired=%0d want 0/0", obs(), retired);
        end
        exp_ret = 0;
    endtask

    task automatic test_start();
        logic [13:0] e;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = '0; e[5] = 1'b1; e[4] = 1'b1; e[2] = 1'b1;
        n_checks++;
        if (obs() !== e || entryPoint !== ENTRY || retired !== 16'(exp_ret)) begin
            n_fail++;
            $display("FAIL load: ctl=%b ep=%h retired=%0d want ctl=%b ep=%h retired=%0d", obs(), entryPoint, retired, e, ENTRY, exp_ret);
        end
        @(posedge clk); #1;
        e = '0; e[3] = 1'b1; e[2] = 1'b1;
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL first_fetch: ctl=%b want %b", obs(), e);
        end
    endtask

    task automatic test_sub();
        run_instr("sub", 32'h40208033);
    endtask

    task automatic test_lw_sw();
        run_instr("lw", 32'h00402083);
        run_instr("sw", 32'h00102223);
    endtask

    task automatic test_random_halt();
        logic [13:0] e, m;
        while (exp_ret < LIMIT) run_instr("rand", rand_ins());
        e = '0; e[1] = 1'b1;
        m = '1; m[12] = 1'b0; m[8:6] = 3'b000;
        n_checks++;
        if ((obs() & m) !== e || retired !== 16'(LIMIT)) begin
            n_fail++;
            $display("FAIL halt: ctl=%b retired=%0d want %b / %0d", obs(), retired, e, LIMIT);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ((obs() & m) !== e || retired !== 16'(LIMIT)) begin
                n_fail++;
                $display("FAIL halt_ignores_start %0d: ctl=%b retired=%0d want %b / %0d", i, obs(), retired, e, LIMIT);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_nop();
        test_reset();
        test_start();
`ifdef CPU_SEQ_TRAP_EN
        ins = 32'h0000007F;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (trap !== 1'b1 || busy !== 1'b0 || pc_en !== 1'b0 || retired !== 16'(exp_ret)) begin
            n_fail++;
            $display("FAIL trap: trap=%b busy=%b pc_en=%b retired=%0d want 1/0/0/%0d", trap, busy, pc_en, retired, exp_ret);
        end
`else
        run_instr("nop", 32'h0000007F);
`endif
    endtask

    task automatic test_reset_mid_mem();
        test_reset();
        test_start();
        run_instr("addi", 32'h00100093);
        ins = 32'h00102223;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (MemWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_mem_before_reset: MemWrite=%b want 1", MemWrite);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (MemWrite !== 1'b0 || obs() !== 14'd0 || retired !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: MemWrite=%b ctl=%b retired=%0d want 0/0/0", MemWrite, obs(), retired);
        end
        @(negedge clk); rst_n = 1'b1;
        exp_ret = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs() !== 14'd0 || retired !== 16'd0) begin
                n_fail++;
                $display("FAIL post_reset_idle %0d: ctl=%b retired=%0d want 0/0", i, obs(), retired);
            end
        end
    endtask

    task automatic test_limit();
        int cyc, pcs;
        l_rst_n = 1'b0; l_start = 1'b0; l_ins = 32'h00100093;
        repeat (2) @(posedge clk);
        @(negedge clk); l_rst_n = 1'b1;
        @(posedge clk); #1;
        l_start = 1'b1;
        @(posedge clk); #1;
        l_start = 1'b0;
        cyc = 1; pcs = 0;
        while (cyc < 40 && !l_done) begin
            @(posedge clk); #1;
            cyc++;
            if (l_pc) pcs++;
        end
        n_checks++;
        if (cyc !== 14 || pcs !== 3) begin
            n_fail++;
            $display("FAIL limit_timing: done at cycle %0d with %0d pc_en, want cycle 14 with 3", cyc, pcs);
        end
        n_checks++;
        if (l_done !== 1'b1 || l_busy !== 1'b0 || l_ret !== 16'd3) begin
            n_fail++;
            $display("FAIL limit_halt: done=%b busy=%b retired=%0d want 1/0/3", l_done, l_busy, l_ret);
        end
        l_start = 1'b1;
        @(posedge clk); #1;
        l_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (l_done !== 1'b1 || l_busy !== 1'b0 || l_pc !== 1'b0 || l_ir !== 1'b0 || l_rw !== 1'b0 || l_ret !== 16'd3) begin
            n_fail++;
            $display("FAIL limit_start_ignored: done=%b busy=%b pc_en=%b ir_en=%b RegWrite=%b retired=%0d want 1/0/0/0/0/3",
                     l_done, l_busy, l_pc, l_ir, l_rw, l_ret);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ins = '0;
        l_rst_n = 1'b0; l_start = 1'b0; l_ins = '0;
        test_reset();
        test_start();
        test_sub();
        test_lw_sw();
        test_random_halt();
        test_nop();
        test_reset_mid_mem();
        test_limit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
